// File: rtl/bank_swap_ctrl.sv
// Ping-pong bank sequencer: counts host writes into the outside bank, waits for an idle compute engine,
// swaps banks, waits a settle gap and pulses compute_start. All outputs registered; host is gated via host_wr_allowed.
module bank_swap_ctrl #(
    parameter int AWIDTH     = 10,
    parameter int LOAD_WORDS = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int SWAP_GAP   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 outside_wreq,
    input  logic [AWIDTH-1:0]    outside_addr,
    input  logic                 compute_ready,
    input  logic                 compute_done,
    output logic                 memory_status,
    output logic                 host_wr_allowed,
    output logic                 compute_start,
    output logic                 compute_busy,
    output logic [CNT_WIDTH-1:0] load_count,
    output logic [CNT_WIDTH-1:0] swap_count,
    output logic                 proto_err
);

    typedef enum logic [2:0] {S_LOAD, S_READY, S_SWAP, S_GAP, S_START} state_t;

    localparam int                   GW       = $clog2(SWAP_GAP + 2);
    localparam logic [CNT_WIDTH-1:0] LW_CNT   = CNT_WIDTH'(LOAD_WORDS);
    localparam logic [31:0]          LW_ADDR  = 32'(LOAD_WORDS);
    localparam logic [GW-1:0]        GAP_INIT = (SWAP_GAP > 0) ? GW'(SWAP_GAP - 1) : '0;

    state_t               state_q, state_d;
    logic                 ms_q, ms_d;
    logic                 hwa_q, hwa_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic                 perr_q, perr_d;
    logic [CNT_WIDTH-1:0] load_q, load_d;
    logic [CNT_WIDTH-1:0] swap_q, swap_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 addr_ok;
    logic                 wr_ok;
    logic [CNT_WIDTH-1:0] load_inc;

    assign addr_ok  = 32'(outside_addr) < LW_ADDR;
    assign wr_ok    = outside_wreq && (state_q == S_LOAD) && addr_ok;
    assign load_inc = load_q + CNT_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        ms_d    = ms_q;
        busy_d  = busy_q;
        perr_d  = perr_q;
        load_d  = load_q;
        swap_d  = swap_q;
        gap_d   = gap_q;

        if (outside_wreq && !wr_ok) begin
            perr_d = 1'b1;
        end
        if (compute_done) begin
            if (busy_q) begin
                busy_d = 1'b0;
            end else begin
                perr_d = 1'b1;
            end
        end

        // START is evaluated after the done handling so a stray done in START cannot block busy
        case (state_q)
            S_LOAD: begin
                if (wr_ok) begin
                    load_d = load_inc;
                    if (load_inc == LW_CNT) begin
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                if (!busy_q && compute_ready) begin
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                ms_d   = ~ms_q;
                swap_d = swap_q + CNT_WIDTH'(1);
                if (SWAP_GAP == 0) begin
                    state_d = S_START;
                end else begin
                    gap_d   = GAP_INIT;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_START;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            S_START: begin
                busy_d  = 1'b1;
                load_d  = '0;
                state_d = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        start_d = (state_d == S_START);
        hwa_d   = (state_d == S_LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            ms_q    <= 1'b0;
            hwa_q   <= 1'b1;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
            load_q  <= '0;
            swap_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ms_q    <= ms_d;
            hwa_q   <= hwa_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            perr_q  <= perr_d;
            load_q  <= load_d;
            swap_q  <= swap_d;
            gap_q   <= gap_d;
        end
    end

    assign memory_status   = ms_q;
    assign host_wr_allowed = hwa_q;
    assign compute_start   = start_q;
    assign compute_busy    = busy_q;
    assign load_count      = load_q;
    assign swap_count      = swap_q;
    assign proto_err       = perr_q;

endmodule

// File: tb/tb_bank_swap_ctrl.sv
// Bench for bank_swap_ctrl: instance A uses default parameters, instance B uses LOAD_WORDS=1, SWAP_GAP=0.
// Expected compute_start events are queued at READY and popped when the DUT pulses start.
module tb_bank_swap_ctrl;

    typedef struct {
        logic       ms;
        logic [7:0] sw;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t qa[$];
    exp_t qb[$];

    // Instance A
    logic       a_rst_n, a_wreq, a_ready, a_done;
    logic [9:0] a_addr;
    logic       a_ms, a_hwa, a_start, a_busy, a_perr;
    logic [7:0] a_lc, a_sw;

    // Instance B
    logic       b_rst_n, b_wreq, b_ready, b_done;
    logic [9:0] b_addr;
    logic       b_ms, b_hwa, b_start, b_busy, b_perr;
    logic [7:0] b_lc, b_sw;

    bank_swap_ctrl #(.AWIDTH(10), .LOAD_WORDS(16), .CNT_WIDTH(8), .SWAP_GAP(2)) u_dut_a (
        .clk(clk), .rst_n(a_rst_n), .outside_wreq(a_wreq), .outside_addr(a_addr),
        .compute_ready(a_ready), .compute_done(a_done), .memory_status(a_ms),
        .host_wr_allowed(a_hwa), .compute_start(a_start), .compute_busy(a_busy),
        .load_count(a_lc), .swap_count(a_sw), .proto_err(a_perr)
    );

    bank_swap_ctrl #(.AWIDTH(10), .LOAD_WORDS(1), .CNT_WIDTH(8), .SWAP_GAP(0)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .outside_wreq(b_wreq), .outside_addr(b_addr),
        .compute_ready(b_ready), .compute_done(b_done), .memory_status(b_ms),
        .host_wr_allowed(b_hwa), .compute_start(b_start), .compute_busy(b_busy),
        .load_count(b_lc), .swap_count(b_sw), .proto_err(b_perr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic a_write(input int addr);
        a_wreq = 1'b1;
        a_addr = 10'(addr);
        step();
        a_wreq = 1'b0;
    endtask

    task automatic a_reset();
        a_rst_n = 1'b0;
        step();
        a_rst_n = 1'b1;
    endtask

    task automatic a_check_reset(input string tag);
        check({tag, "_ms"},    a_ms,    0);
        check({tag, "_hwa"},   a_hwa,   1);
        check({tag, "_start"}, a_start, 0);
        check({tag, "_busy"},  a_busy,  0);
        check({tag, "_lc"},    a_lc,    0);
        check({tag, "_sw"},    a_sw,    0);
        check({tag, "_perr"},  a_perr,  0);
    endtask

    // Scoreboard monitors: pop on every compute_start and enforce the pulse / bank-stability rules
    logic a_start_prev = 1'b0, a_ms_prev = 1'b0, a_busy_prev = 1'b0;
    logic b_start_prev = 1'b0, b_ms_prev = 1'b0, b_busy_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (a_start === 1'b1) begin
            ok = (qa.size() > 0);
            check("a_start_expected", ok, 1);
            if (ok) begin
                e = qa.pop_front();
                check("a_start_cycle", cyc, e.cyc);
                check("a_start_ms", a_ms, e.ms);
                check("a_start_swaps", a_sw, e.sw);
            end
            check("a_start_consec", a_start_prev, 0);
        end
        if (a_ms !== a_ms_prev) check("a_ms_while_busy", a_busy_prev, 0);
        a_start_prev = a_start;
        a_ms_prev    = a_ms;
        a_busy_prev  = a_busy;

        if (b_start === 1'b1) begin
            ok = (qb.size() > 0);
            check("b_start_expected", ok, 1);
            if (ok) begin
                e = qb.pop_front();
                check("b_start_cycle", cyc, e.cyc);
                check("b_start_ms", b_ms, e.ms);
                check("b_start_swaps", b_sw, e.sw);
            end
            check("b_start_consec", b_start_prev, 0);
        end
        if (b_ms !== b_ms_prev) check("b_ms_while_busy", b_busy_prev, 0);
        b_start_prev = b_start;
        b_ms_prev    = b_ms;
        b_busy_prev  = b_busy;
    end

    initial begin
        a_rst_n = 1'b0; a_wreq = 1'b0; a_addr = '0; a_ready = 1'b0; a_done = 1'b0;
        b_rst_n = 1'b0; b_wreq = 1'b0; b_addr = '0; b_ready = 1'b1; b_done = 1'b0;
        step();
        step();
        a_check_reset("rst");
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // First load: 16 writes, swap, start
        a_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_write(i);
            if (i < 3 || i == 15) check("a_load_count", a_lc, i + 1);
        end
        check("a_ready_state", a_hwa, 0);
        qa.push_back('{ms: 1'b1, sw: 8'd1, cyc: cyc + 4});
        step();
        check("a_swap_ms_old", a_ms, 0);
        step();
        check("a_swap_ms_new", a_ms, 1);
        step();
        step();
        step();
        check("a_after_start_busy", a_busy, 1);
        check("a_after_start_lc", a_lc, 0);
        check("a_after_start_hwa", a_hwa, 1);
        check("a_after_start_sw", a_sw, 1);

        // Second load while compute still busy: must hold in READY
        for (int i = 0; i < 16; i++) a_write(15 - i);
        repeat (4) step();
        check("a_hold_hwa", a_hwa, 0);
        check("a_hold_ms", a_ms, 1);
        check("a_hold_lc", a_lc, 16);
        a_done = 1'b1;
        step();
        a_done = 1'b0;
        check("a_done_clears_busy", a_busy, 0);
        qa.push_back('{ms: 1'b0, sw: 8'd2, cyc: cyc + 4});
        step();
        step();
        check("a_swap2_ms", a_ms, 0);
        step();
        step();
        step();
        check("a_swap2_busy", a_busy, 1);
        check("a_swap2_sw", a_sw, 2);
        check("a_swap2_perr", a_perr, 0);

        // Out-of-range address in LOAD
        a_reset();
        a_write(20);
        check("a_oor_perr", a_perr, 1);
        check("a_oor_lc", a_lc, 0);
        check("a_oor_hwa", a_hwa, 1);

        // compute_done while idle
        a_reset();
        a_done = 1'b1;
        step();
        a_done = 1'b0;
        check("a_idle_done_perr", a_perr, 1);
        check("a_idle_done_ms", a_ms, 0);
        check("a_idle_done_hwa", a_hwa, 1);
        check("a_idle_done_busy", a_busy, 0);

        // Write while in READY, compute not ready
        a_reset();
        a_ready = 1'b0;
        for (int i = 0; i < 16; i++) a_write(i);
        check("a_ready_perr_pre", a_perr, 0);
        a_write(3);
        check("a_ready_wr_perr", a_perr, 1);
        check("a_ready_wr_lc", a_lc, 16);
        check("a_ready_wr_hwa", a_hwa, 0);
        repeat (3) step();
        check("a_not_ready_ms", a_ms, 0);

        // Reset in the middle of GAP: no start may follow
        a_ready = 1'b1;
        step();
        check("a_gap_swap_ms", a_ms, 0);
        step();
        check("a_gap_ms", a_ms, 1);
        a_rst_n = 1'b0;
        step();
        a_check_reset("gap_rst");
        a_rst_n = 1'b1;
        repeat (6) step();
        check("a_post_rst_hwa", a_hwa, 1);
        check("a_post_rst_ms", a_ms, 0);

        // Instance B: one word per load, no gap, 256 rounds wrap swap_count
        for (int r = 0; r < 256; r++) begin
            b_wreq = 1'b1;
            b_addr = '0;
            step();
            b_wreq = 1'b0;
            if (r < 3) begin
                check("b_ready_hwa", b_hwa, 0);
                check("b_ready_lc", b_lc, 1);
            end
            qb.push_back('{ms: 1'(r + 1), sw: 8'(r + 1), cyc: cyc + 2});
            step();
            step();
            step();
            if (r < 3) check("b_busy", b_busy, 1);
            b_done = 1'b1;
            step();
            b_done = 1'b0;
        end
        check("b_swap_wrap", b_sw, 0);
        check("b_ms_even", b_ms, 0);
        check("b_perr", b_perr, 0);

        check("a_sb_empty", qa.size(), 0);
        check("b_sb_empty", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
